// File: rtl/vx_ibuffer_mw_pkg.sv
// Shared types and defaults for the multi-warp instruction buffer.
package vx_ibuffer_mw_pkg;

   localparam int unsigned IBUF_NUM_WARPS = 4;
   localparam int unsigned IBUF_DEPTH     = 4;

   // Decoded instruction as carried from decode to issue (128 bits).
   typedef struct packed {
      logic [31:0] uuid;
      logic [3:0]  tmask;
      logic [31:0] pc;
      logic [2:0]  ex_type;
      logic [4:0]  op_type;
      logic [22:0] op_args;
      logic        wb;
      logic [6:0]  rd;
      logic [6:0]  rs1;
      logic [6:0]  rs2;
      logic [6:0]  rs3;
   } ibuf_entry_t;

   localparam int unsigned IBUF_ENTRY_W = $bits(ibuf_entry_t);

endpackage

// File: rtl/vx_ibuffer_mw_queue.sv
// Single per-warp FIFO: push, pop, synchronous clear, full/empty and head data.
module vx_ibuffer_mw_queue
   import vx_ibuffer_mw_pkg::*;
#(
   parameter int unsigned DEPTH  = IBUF_DEPTH,
   parameter int unsigned DATA_W = IBUF_ENTRY_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [DATA_W-1:0] o_head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_rd;
   logic [PTR_W-1:0]  r_wr;
   logic [CNT_W-1:0]  r_cnt;

   // Storage array; a cleared push is dropped.
   always_ff @(posedge clk) begin
      if (i_push && !i_clear) begin
         r_mem[r_wr] <= i_data;
      end
   end

   // Pointers and occupancy; clear empties the queue, pointers wrap naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else if (i_clear) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + PTR_W'(1);
         if (i_pop)  r_rd <= r_rd + PTR_W'(1);
         r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   assign o_full  = (r_cnt == CNT_W'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/vx_ibuffer_mw.sv
// Multi-warp instruction buffer: NUM_WARPS per-warp FIFOs, one enqueue port,
// one issue port with round-robin warp selection and a grant lock that keeps
// the offered instruction stable until issue accepts it.
// Optional feature: define VX_IBUF_FLUSH_EN to add the per-warp flush port.
module vx_ibuffer_mw
   import vx_ibuffer_mw_pkg::*;
#(
   parameter  int unsigned NUM_WARPS = IBUF_NUM_WARPS,
   parameter  int unsigned DEPTH     = IBUF_DEPTH,
   parameter  int unsigned DATA_W    = IBUF_ENTRY_W,
   localparam int unsigned WID_W     = $clog2(NUM_WARPS)
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [WID_W-1:0]     in_wid,
   input  logic [DATA_W-1:0]    in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [WID_W-1:0]     out_wid,
   output logic [DATA_W-1:0]    out_data,
`ifdef VX_IBUF_FLUSH_EN
   input  logic [NUM_WARPS-1:0] flush,
`endif
   input  logic                 out_ready,
   input  logic [NUM_WARPS-1:0] warp_stall
);

   localparam logic [WID_W-1:0] LAST_WID = WID_W'(NUM_WARPS - 1);

   logic [NUM_WARPS-1:0] w_full;
   logic [NUM_WARPS-1:0] w_empty;
   logic [NUM_WARPS-1:0] w_elig;
   logic [NUM_WARPS-1:0] w_flush;
   logic [DATA_W-1:0]    w_head [NUM_WARPS];

   logic                 r_lock;
   logic [WID_W-1:0]     r_lock_wid;
   logic [WID_W-1:0]     r_rr;

   logic                 w_found;
   logic [WID_W-1:0]     w_idx;
   logic [WID_W-1:0]     w_rr_grant;
   logic                 w_out_valid;
   logic [WID_W-1:0]     w_out_wid;
   logic                 w_in_ready;
   logic                 w_fire;
   logic [WID_W-1:0]     w_rr_next;

`ifdef VX_IBUF_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = '0;
`endif

   // One FIFO per warp; flush drops a same-cycle enqueue to that warp.
   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_q
      vx_ibuffer_mw_queue #(
         .DEPTH  (DEPTH),
         .DATA_W (DATA_W)
      ) u_q (
         .clk     (clk),
         .reset   (reset),
         .i_push  (in_valid && w_in_ready && (in_wid == WID_W'(w))),
         .i_pop   (w_fire && (w_out_wid == WID_W'(w))),
         .i_clear (w_flush[w]),
         .i_data  (in_data),
         .o_full  (w_full[w]),
         .o_empty (w_empty[w]),
         .o_head  (w_head[w])
      );
   end

   assign w_elig = ~w_empty & ~warp_stall;

   // Round-robin search: first eligible warp at or after r_rr, wrapping.
   always_comb begin
      w_found    = 1'b0;
      w_rr_grant = '0;
      w_idx      = '0;
      for (int unsigned i = 0; i < NUM_WARPS; i++) begin
         w_idx = WID_W'((32'(r_rr) + i) % NUM_WARPS);
         if (!w_found && w_elig[w_idx]) begin
            w_found    = 1'b1;
            w_rr_grant = w_idx;
         end
      end
   end

   // A locked grant overrides the search and ignores warp_stall.
   assign w_out_valid = r_lock | w_found;
   assign w_out_wid   = r_lock ? r_lock_wid : w_rr_grant;
   assign w_fire      = w_out_valid & out_ready;
   assign w_rr_next   = (w_out_wid == LAST_WID) ? '0 : w_out_wid + WID_W'(1);
   assign w_in_ready  = ~w_full[in_wid];

   // Grant lock and round-robin pointer; only a handshake moves r_rr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lock     <= 1'b0;
         r_lock_wid <= '0;
         r_rr       <= '0;
      end else if (w_fire) begin
         r_lock <= 1'b0;
         r_rr   <= w_rr_next;
      end else if (w_out_valid && !w_flush[w_out_wid]) begin
         r_lock     <= 1'b1;
         r_lock_wid <= w_out_wid;
      end else begin
         r_lock <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_wid   = w_out_wid;
   assign out_data  = w_head[w_out_wid];

endmodule
